// File: rtl/inv_key_schedule_if.sv
// Handshake/bus bundle between the key scheduler and its user.
// master: drives start/key and observes the replayed round keys.
// slave : the scheduler itself.
interface inv_key_schedule_if;
    logic         start;
    logic [127:0] key;
    logic [127:0] roundKey;
    logic         keyValid;
    logic         cipherReset;
    logic         done;
    logic         busy;

    modport master (
        output start, key,
        input  roundKey, keyValid, cipherReset, done, busy
    );

    modport slave (
        input  start, key,
        output roundKey, keyValid, cipherReset, done, busy
    );
endinterface

// File: rtl/inv_key_schedule.sv
// AES-128 round-key scheduler for the inverse cipher.
// Expands the cipher key one round per cycle into an 11-entry buffer, then
// replays it from key 10 down to key 0 with cipher reset/done controls.
// Optional build macro: INV_KEY_SCHEDULE_CACHE_EN - when defined, a start with
// the same key as the last completed expansion skips EXPAND (one PRIME cycle).
//
// state  | meaning
// IDLE   | waiting for start after reset
// EXPAND | computing buf[cnt] from buf[cnt-1], cnt = 1..10
// PRIME  | cache hit: one cycle of cipherReset before replay
// PLAY   | presenting buf[idx], idx = 10..0
// DONE   | holding key 0 with done high until the next start
module inv_key_schedule #(
    parameter int NR = 10
) (
    input logic           clk,
    input logic           reset,
    inv_key_schedule_if.slave ks
);
    localparam logic [3:0] LAST = 4'(NR);

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    typedef enum logic [2:0] {S_IDLE, S_EXPAND, S_PRIME, S_PLAY, S_DONE} state_t;

    state_t       state, state_nxt;
    logic [3:0]   cnt, idx;
    logic [127:0] key_buf [0:NR];
    logic [127:0] round_key;
    logic [127:0] prev_key, next_key;
    logic [31:0]  w3_rot, sub_rot;
    logic [7:0]   rcon;
    logic         start_ok, cache_hit;
    logic         key_valid, cipher_reset, done_o, busy_o;

    // Only AES-128 is implemented; flag any other round count in simulation.
    nr_supported: assert property (@(posedge clk) NR == 10)
        else $error("inv_key_schedule: NR=%0d unsupported, only 10", NR);

    assign start_ok = ks.start && (state == S_IDLE || state == S_DONE);

`ifdef INV_KEY_SCHEDULE_CACHE_EN
    logic cache_valid;

    // Cache is valid only after a complete expansion of the key now in buf[0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cache_valid <= 1'b0;
        else if (start_ok && ks.key != key_buf[0])
            cache_valid <= 1'b0;
        else if (state == S_EXPAND && cnt == LAST)
            cache_valid <= 1'b1;
    end

    assign cache_hit = cache_valid && (ks.key == key_buf[0]);
`else
    assign cache_hit = 1'b0;
`endif

    // One FIPS-197 expansion step: buf[cnt-1] -> buf[cnt].
    always_comb begin
        prev_key = key_buf[cnt - 4'd1];
        w3_rot   = {prev_key[23:0], prev_key[31:24]};
        sub_rot  = {SBOX[w3_rot[31:24]], SBOX[w3_rot[23:16]],
                    SBOX[w3_rot[15:8]],  SBOX[w3_rot[7:0]]};
        case (cnt)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        next_key[127:96] = prev_key[127:96] ^ sub_rot ^ {rcon, 24'h0};
        next_key[95:64]  = prev_key[95:64]  ^ next_key[127:96];
        next_key[63:32]  = prev_key[63:32]  ^ next_key[95:64];
        next_key[31:0]   = prev_key[31:0]   ^ next_key[63:32];
    end

    // Next-state and control outputs.
    always_comb begin
        state_nxt    = state;
        key_valid    = 1'b0;
        cipher_reset = 1'b0;
        done_o       = 1'b0;
        busy_o       = 1'b0;
        case (state)
            S_IDLE: begin
                if (ks.start) state_nxt = cache_hit ? S_PRIME : S_EXPAND;
            end
            S_EXPAND: begin
                busy_o = 1'b1;
                if (cnt == LAST) begin
                    cipher_reset = 1'b1;
                    state_nxt    = S_PLAY;
                end
            end
            S_PRIME: begin
                busy_o       = 1'b1;
                cipher_reset = 1'b1;
                state_nxt    = S_PLAY;
            end
            S_PLAY: begin
                busy_o    = 1'b1;
                key_valid = 1'b1;
                if (idx == 4'd0) begin
                    done_o    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done_o = 1'b1;
                if (ks.start) state_nxt = cache_hit ? S_PRIME : S_EXPAND;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, counters and the registered round-key output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            idx       <= 4'd0;
            round_key <= 128'h0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE, S_DONE: begin
                    if (ks.start) begin
                        cnt       <= 4'd1;
                        round_key <= 128'h0;
                    end
                end
                S_EXPAND: begin
                    if (cnt == LAST) begin
                        cnt       <= 4'd0;
                        idx       <= LAST;
                        round_key <= next_key;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_PRIME: begin
                    cnt       <= 4'd0;
                    idx       <= LAST;
                    round_key <= key_buf[LAST];
                end
                S_PLAY: begin
                    if (idx != 4'd0) begin
                        idx       <= idx - 4'd1;
                        round_key <= key_buf[idx - 4'd1];
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-key buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (start_ok)
            key_buf[0] <= ks.key;
        else if (state == S_EXPAND)
            key_buf[cnt] <= next_key;
    end

    assign ks.roundKey    = round_key;
    assign ks.keyValid    = key_valid;
    assign ks.cipherReset = cipher_reset;
    assign ks.done        = done_o;
    assign ks.busy        = busy_o;
endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule with FIPS-197 key-expansion vectors.
// Build with +define+INV_KEY_SCHEDULE_CACHE_EN to exercise the cache option.
module tb_inv_key_schedule;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K1_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2_R9  = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] K2_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K0     = 128'h0;
    localparam logic [127:0] K0_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] K0_R9  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    localparam logic [127:0] K0_R1  = 128'h62636363626363636263636362636363;

`ifdef INV_KEY_SCHEDULE_CACHE_EN
    localparam int REPEAT_K10_CYC = 2;
`else
    localparam int REPEAT_K10_CYC = 11;
`endif

    inv_key_schedule_if ks_if ();

    inv_key_schedule dut (
        .clk   (clk),
        .reset (reset),
        .ks    (ks_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_rk"},   ks_if.roundKey, 128'h0);
        check_val({tag, "_ctl"},
                  {ks_if.keyValid, ks_if.cipherReset, ks_if.done, ks_if.busy}, 4'b0000);
    endtask

    // Start in cycle 0 (sampled at its closing edge) and watch one full run.
    task automatic run_obs(input string tag, input logic [127:0] k, input int k10_cyc,
                           input bit repulse, input logic [127:0] e10, input logic [127:0] e9,
                           input logic [127:0] e1, input logic [127:0] e0);
        int cr_first, cr_cnt, busy_cnt, kv_first, done_first;
        logic [127:0] got10, got9, got1, got0;
        cr_first = -1; cr_cnt = 0; busy_cnt = 0; kv_first = -1; done_first = -1;
        got10 = '0; got9 = '0; got1 = '0; got0 = '0;
        @(negedge clk);
        ks_if.start = 1'b1;
        ks_if.key   = k;
        for (int c = 1; c <= k10_cyc + 12; c++) begin
            @(negedge clk);
            ks_if.start = repulse && (c == 3 || c == 15);
            if (ks_if.cipherReset) begin
                cr_cnt++;
                if (cr_first < 0) cr_first = c;
            end
            if (ks_if.busy) busy_cnt++;
            if (ks_if.keyValid && kv_first < 0) kv_first = c;
            if (c == k10_cyc)     got10 = ks_if.roundKey;
            if (c == k10_cyc + 1) got9  = ks_if.roundKey;
            if (c == k10_cyc + 9) got1  = ks_if.roundKey;
            if (ks_if.done && done_first < 0) begin
                done_first = c;
                got0 = ks_if.roundKey;
            end
        end
        ks_if.start = 1'b0;
        check_val({tag, "_cr_cycle"},   cr_first,   k10_cyc - 1);
        check_val({tag, "_cr_count"},   cr_cnt,     1);
        check_val({tag, "_busy_count"}, busy_cnt,   k10_cyc + 10);
        check_val({tag, "_kv_cycle"},   kv_first,   k10_cyc);
        check_val({tag, "_done_cycle"}, done_first, k10_cyc + 10);
        check_val({tag, "_key10"}, got10, e10);
        check_val({tag, "_key9"},  got9,  e9);
        check_val({tag, "_key1"},  got1,  e1);
        check_val({tag, "_key0"},  got0,  e0);
        check_val({tag, "_end_ctl"},
                  {ks_if.keyValid, ks_if.cipherReset, ks_if.done, ks_if.busy}, 4'b0010);
        check_val({tag, "_end_rk"}, ks_if.roundKey, e0);
    endtask

    initial begin
        int bad;
        int wait_cnt;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        ks_if.start = 1'b0;
        ks_if.key   = '0;

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle");

        run_obs("t1_fips", K1, 11, 1'b0, K1_R10, K1_R9, K1_R1, K1);
        run_obs("t2_seq",  K2, 11, 1'b0, K2_R10, K2_R9, K2_R1, K2);
        run_obs("t3_repulse", K1, 11, 1'b1, K1_R10, K1_R9, K1_R1, K1);

        // Hold in DONE: outputs must not move without a start.
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (ks_if.done !== 1'b1 || ks_if.keyValid !== 1'b0 ||
                ks_if.cipherReset !== 1'b0 || ks_if.busy !== 1'b0 || ks_if.roundKey !== K1)
                bad++;
        end
        check_val("t6_hold_bad_cycles", bad, 0);
        check_val("t6_hold_rk", ks_if.roundKey, K1);

        // Asynchronous reset in the middle of cycle 14 of a run.
        @(negedge clk);
        ks_if.start = 1'b1;
        ks_if.key   = K1;
        @(negedge clk);
        ks_if.start = 1'b0;
        repeat (13) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_idle_outputs("t4_async_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("t4_after_reset");
        run_obs("t4_rerun", K1, 11, 1'b0, K1_R10, K1_R9, K1_R1, K1);

        run_obs("t5_repeat", K1, REPEAT_K10_CYC, 1'b0, K1_R10, K1_R9, K1_R1, K1);
        run_obs("zero_key", K0, 11, 1'b0, K0_R10, K0_R9, K0_R1, K0);

        // start held high: DONE lasts one cycle, then a new run begins.
        @(negedge clk);
        ks_if.start = 1'b1;
        ks_if.key   = K0;
        wait_cnt = 0;
        do begin
            @(negedge clk);
            wait_cnt++;
        end while (!(ks_if.done && ks_if.keyValid) && wait_cnt < 40);
        check_val("held_first_done_seen", wait_cnt < 40, 1'b1);
        @(negedge clk);
        check_val("held_in_done", {ks_if.done, ks_if.keyValid, ks_if.busy}, 3'b100);
        check_val("held_done_rk", ks_if.roundKey, K0);
        @(negedge clk);
        check_val("held_restart", {ks_if.done, ks_if.busy}, 2'b01);
        ks_if.start = 1'b0;
        wait_cnt = 0;
        do begin
            @(negedge clk);
            wait_cnt++;
        end while (!(ks_if.done && !ks_if.busy) && wait_cnt < 40);
        check_val("held_second_done_seen", wait_cnt < 40, 1'b1);
        check_val("held_second_rk", ks_if.roundKey, K0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
